// File: rtl/alu32_issue_wb.sv
// Operand-issue and writeback stage around the combinational alu32: register file,
// registered EX stage feeding the ALU, and a one-entry response buffer with backpressure.
module alu32_issue_wb #(
  parameter int DW   = 32,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [2:0]    cmd_rd,
  input  logic [2:0]    cmd_rs1,
  input  logic [2:0]    cmd_rs2,
  input  logic          cmd_imm_sel,
  input  logic [DW-1:0] cmd_imm,
  input  logic          cmd_we,
  input  logic          cmd_fe,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_c,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic [3:0]    rsp_flags,
  output logic [2:0]    rsp_rd,
  output logic [3:0]    flags
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] ex_a_q, ex_a_d;
  logic [DW-1:0] ex_b_q, ex_b_d;
  logic [2:0]    ex_op_q, ex_op_d;
  logic [2:0]    ex_rd_q, ex_rd_d;
  logic          ex_we_q, ex_we_d;
  logic          ex_fe_q, ex_fe_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_flags_q, rsp_flags_d;
  logic [2:0]    rsp_rd_q, rsp_rd_d;
  logic [3:0]    flags_q, flags_d;

  logic          adv;
  logic          wb_en;
  logic          accept;
  logic [DW-1:0] src1, src2;

  // Register read with bypass of the result being written back on this same edge.
  function automatic logic [DW-1:0] read_operand(
    input logic [2:0]    idx,
    input logic          wb_hit,
    input logic [2:0]    wb_rd,
    input logic [DW-1:0] wb_val,
    input logic [DW-1:0] rf_val
  );
    if (idx == 3'd0)
      return '0;
    else if (wb_hit && (wb_rd == idx))
      return wb_val;
    else
      return rf_val;
  endfunction

  always_comb begin
    adv       = ex_valid_q && (!rsp_valid_q || rsp_ready);
    wb_en     = adv && ex_we_q && (ex_rd_q != 3'd0);
    cmd_ready = !reset && (!ex_valid_q || adv);
    accept    = cmd_valid && cmd_ready;

    src1 = read_operand(cmd_rs1, wb_en, ex_rd_q, alu_result, regs_q[cmd_rs1]);
    src2 = cmd_imm_sel ? cmd_imm
                       : read_operand(cmd_rs2, wb_en, ex_rd_q, alu_result, regs_q[cmd_rs2]);
  end

  // Issue -> EX boundary
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    ex_fe_d    = ex_fe_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_a_d     = src1;
      ex_b_d     = src2;
      ex_op_d    = cmd_op;
      ex_rd_d    = cmd_rd;
      ex_we_d    = cmd_we;
      ex_fe_d    = cmd_fe;
    end else if (adv) begin
      ex_valid_d = 1'b0;
    end
  end

  // EX -> writeback / response boundary
  always_comb begin
    regs_d       = regs_q;
    flags_d      = flags_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_rd_d     = rsp_rd_q;
    if (wb_en)
      regs_d[ex_rd_q] = alu_result;
    if (adv && ex_fe_q)
      flags_d = {alu_c, alu_n, alu_z, alu_v};
    if (adv) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_flags_d  = {alu_c, alu_n, alu_z, alu_v};
      rsp_rd_d     = ex_rd_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q       <= '{default: '0};
      ex_valid_q   <= 1'b0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_op_q      <= '0;
      ex_rd_q      <= '0;
      ex_we_q      <= 1'b0;
      ex_fe_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_rd_q     <= '0;
      flags_q      <= '0;
    end else begin
      regs_q       <= regs_d;
      ex_valid_q   <= ex_valid_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_op_q      <= ex_op_d;
      ex_rd_q      <= ex_rd_d;
      ex_we_q      <= ex_we_d;
      ex_fe_q      <= ex_fe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_rd_q     <= rsp_rd_d;
      flags_q      <= flags_d;
    end
  end

  assign alu_a      = ex_a_q;
  assign alu_b      = ex_b_q;
  assign alu_op     = ex_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_rd     = rsp_rd_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu32_issue_wb.sv
// Bench for alu32_issue_wb: behavioural alu32 stand-in, sequential architectural
// reference model (registers, flags, ordered response queue), directed and random stimulus.
module tb_alu32_issue_wb;
  localparam int DW = 32;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
  logic          cmd_imm_sel, cmd_we, cmd_fe;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_c, alu_n, alu_z, alu_v;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags, flags;
  logic [2:0]    rsp_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops     = 0;
  logic [31:0] last_result;
  logic [3:0]  last_flags;
  bit rnd_on;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rf;
    logic [2:0]  rd;
    logic [3:0]  af;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mregs[8];
  logic [3:0]  mflags;

  alu32_issue_wb #(.DW(DW), .NREG(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_we(cmd_we), .cmd_fe(cmd_fe),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_rd(rsp_rd), .flags(flags)
  );

  // alu32 behaviour: returns {c,n,z,v,result}
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = b;
    endcase
    return {c, r[31], (r == 32'd0), v, r};
  endfunction

  always_comb {alu_c, alu_n, alu_z, alu_v, alu_result} = alu_f(alu_a, alu_b, alu_op);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mflags = '0;
    exp_q.delete();
  endtask

  // Architectural model: each accepted command executes completely, in order.
  task automatic model_accept();
    logic [31:0] a, b;
    logic [35:0] o;
    rsp_t e;
    a = (cmd_rs1 == 3'd0) ? 32'd0 : mregs[cmd_rs1];
    b = cmd_imm_sel ? cmd_imm : ((cmd_rs2 == 3'd0) ? 32'd0 : mregs[cmd_rs2]);
    o = alu_f(a, b, cmd_op);
    if (cmd_we && cmd_rd != 3'd0) mregs[cmd_rd] = o[31:0];
    if (cmd_fe) mflags = o[35:32];
    e.res = o[31:0];
    e.rf  = o[35:32];
    e.rd  = cmd_rd;
    e.af  = mflags;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_result", rsp_result, e.res);
          check_eq("rsp_flags", rsp_flags, e.rf);
          check_eq("rsp_rd", rsp_rd, e.rd);
          check_eq("arch_flags", flags, e.af);
          last_result = rsp_result;
          last_flags  = rsp_flags;
          pops++;
        end
      end
      if (cmd_valid && cmd_ready) model_accept();
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic isel, input logic [31:0] imm,
                       input logic we, input logic fe);
    int n;
    n = 0;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_sel = isel; cmd_imm = imm; cmd_we = we; cmd_fe = fe;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("issue_timeout", 1, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check_eq("drain_idle", rsp_valid, 0);
  endtask

  initial begin
    int c0, p0;
    logic [31:0] sa, sb;
    logic [2:0]  sop;
    logic [31:0] imm;

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1; rnd_on = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_imm_sel = 1'b0; cmd_imm = '0; cmd_we = 1'b0; cmd_fe = 1'b0;
    last_result = '0; last_flags = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_flags", flags, 0);
    check_eq("reset_alu_a", alu_a, 0);
    check_eq("reset_alu_b", alu_b, 0);
    check_eq("reset_alu_op", alu_op, 0);
    check_eq("reset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_reset_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Signed overflow with the r2 operand forwarded from the previous command
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();
    check_eq("ovf_result", last_result, 32'h8000_0000);
    check_eq("ovf_rsp_flags", last_flags, 4'b0101);
    check_eq("ovf_arch_flags", flags, 4'b0101);

    // Compare into r0: flags update, r0 stays zero
    issue(OP_SUB, 3'd0, 3'd1, 3'd1, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();
    check_eq("cmp_result", last_result, 0);
    check_eq("cmp_z", last_flags[1], 1);
    check_eq("cmp_arch_z", flags[1], 1);
    issue(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    drain();
    check_eq("r0_read", last_result, 0);

    // Backpressure: two absorbed, third waits with EX stable
    p0 = pops;
    rsp_ready = 1'b0;
    issue(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'd11, 1'b1, 1'b0);
    issue(OP_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 32'd22, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("bp_cmd_ready_low", cmd_ready, 0);
    check_eq("bp_rsp_valid", rsp_valid, 1);
    check_eq("bp_fwd_a", alu_a, 32'd11);
    sa = alu_a; sb = alu_b; sop = alu_op;
    cmd_op = OP_ADD; cmd_rd = 3'd6; cmd_rs1 = 3'd5; cmd_rs2 = 3'd0;
    cmd_imm_sel = 1'b1; cmd_imm = 32'd33; cmd_we = 1'b1; cmd_fe = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_stall_ready", cmd_ready, 0);
      check_eq("bp_stable_a", alu_a, sa);
      check_eq("bp_stable_b", alu_b, sb);
      check_eq("bp_stable_op", alu_op, sop);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain();
    check_eq("bp_rsp_count", pops - p0, 3);
    check_eq("bp_last", last_result, 32'd66);

    // Reset with EX and RSP both full
    rsp_ready = 1'b0;
    issue(OP_ADD, 3'd5, 3'd1, 3'd0, 1'b1, 32'd3, 1'b1, 1'b1);
    issue(OP_ADD, 3'd6, 3'd1, 3'd0, 1'b1, 32'd4, 1'b1, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_flags", flags, 0);
    check_eq("midrst_alu_a", alu_a, 0);
    check_eq("midrst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check_eq("midrst_release_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) begin
      issue(OP_ADD, 3'd0, 3'd0, 3'(i), 1'b0, 32'h0, 1'b0, 1'b0);
      drain();
      check_eq("rst_reg_zero", last_result, 0);
    end

    // Forwarding chain at full throughput
    p0 = pops;
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      issue(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 32'd1, 1'b1, 1'b0);
    check_eq("chain_cycles", cyc - c0, 16);
    drain();
    check_eq("chain_final", last_result, 32'd16);
    check_eq("chain_count", pops - p0, 16);

    // Random traffic with random backpressure
    p0 = pops;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 5))
        0: imm = 32'h0;
        1: imm = 32'h1;
        2: imm = 32'hFFFF_FFFF;
        3: imm = 32'h7FFF_FFFF;
        4: imm = 32'h8000_0000;
        default: imm = $urandom;
      endcase
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm,
            ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    drain();
    check_eq("rand_count", pops - p0, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu32_issue_wb.md
# alu32_issue_wb

Operand-issue and writeback stage wrapped around the combinational `alu32`. It accepts register-level commands over a valid/ready handshake and reads operands from an 8×32 register file. It drives `alu32` from a registered execute (EX) stage. It captures the ALU result and the c/n/z/v flags into the register file, a flag register and a 1-entry response buffer with backpressure. Together with `alu32` it forms the datapath core that later control blocks will sequence.

## Interface
- `DW`, 32, data width; must match `alu32`.
- `NREG`, 8, register count; index width is 3 bits; r0 always reads zero.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on an edge where valid && ready.
- `cmd_op`  in  3  ALU op code, passed through to `alu32` unmodified.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  3 each  destination and source register indices.
- `cmd_imm_sel`  in  1  1: operand b = `cmd_imm`; 0: operand b = reg[rs2].
- `cmd_imm`  in  DW  immediate value.
- `cmd_we`  in  1  write the result to rd.
- `cmd_fe`  in  1  update the flag register.
- `alu_a`, `alu_b`  out  DW  operands to `alu32`, driven directly from EX registers.
- `alu_op`  out  3  op code to `alu32`, driven from the EX register.
- `alu_result`  in  DW  result from `alu32`.
- `alu_c`, `alu_n`, `alu_z`, `alu_v`  in  1 each  flags from `alu32`.
- `rsp_valid`  out  1  response buffer full.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  DW  captured result.
- `rsp_flags`  out  4  captured {c,n,z,v}.
- `rsp_rd`  out  3  destination of the captured op.
- `flags`  out  4  architectural {c,n,z,v} flag register.

## Operation
- **Pipeline:** command → EX registers (`ex_valid`, a, b, op, rd, we, fe) → `alu32` (combinational) → RSP buffer.
- **Advance:** `adv = ex_valid && (!rsp_valid || rsp_ready)`.
  - On `adv`: RSP is loaded with `alu_result`, {c,n,z,v} and rd; `rsp_valid` is set to 1.
  - On `adv`, if `we && rd != 0`: reg[rd] ← `alu_result`.
  - On `adv`, if `fe`: `flags` ← {c,n,z,v}.
- **RSP drain:** if `rsp_valid && rsp_ready && !adv`, then `rsp_valid` ← 0.
- **Command acceptance:** `cmd_ready = !reset && (!ex_valid || adv)`.
  - On accept: EX loads the new operands and `ex_valid` ← 1.
  - Otherwise, if `adv`: `ex_valid` ← 0.
  - If EX is stalled, the EX registers hold and `alu_*` outputs are stable.
- **Operand read:** combinational from the register file at the accept edge.
  - Index 0 yields 0.
  - **Forwarding:** if `adv` occurs on the same edge, EX has `we=1`, and EX `rd` equals rs1 (or rs2 when `imm_sel=0`), with `rd != 0`, then the operand is taken from `alu_result`.
- **Write ordering:** writeback and a new read of the same register on the same edge resolve via forwarding; a stale read is never allowed.
- **Flag write:** `fe=1` with `we=0` updates the flags only (compare semantics).
- **Response buffer:** the response is produced regardless of `we`/`fe`; exactly one response per accepted command, in order.
- **Reset (asynchronous):**
  - `ex_valid=0`, `rsp_valid=0`.
  - All registers, `flags` and `rsp_*` fields = 0.
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - In-flight commands are dropped with no writeback.

## Timing
- A command accepted at edge T is visible on `alu_*` after T.
- If `adv` holds at edge T+1:
  - reg, `flags` and RSP are updated at T+1.
  - `rsp_valid` is high after T+1.
- **Throughput:** one command per cycle while `rsp_ready` is held high.
- **Backpressure** (`rsp_valid=1`, `rsp_ready=0`):
  - EX holds and `adv=0`.
  - `cmd_ready=0` if EX is full, else 1: one more command is absorbed, then the block stalls.
- **Max in flight:** two commands (EX + RSP).
- **Reset mid-stall:** all valids clear immediately (asynchronous); `cmd_ready` is 0 while reset is high and 1 on the first cycle after release.

## Test plan
- **Reset:** assert reset mid-stream with EX and RSP full → `rsp_valid=0`, `flags=0`, `alu_a=0` immediately. Reading r1..r7 afterwards (ADD r0+r_i, imm_sel=0) returns 0.
- **Overflow add:**
  - ADD r1=r0+imm 0x7FFFFFFF, then ADD r2=r0+imm 1.
  - Then ADD r3=r1+r2 with fe=1, back-to-back so the r2 operand is forwarded.
  - Required: `rsp_result=0x80000000`, `rsp_flags` c=0 n=1 z=0 v=1, and `flags` equal to `rsp_flags`.
- **Write to r0 / compare:** SUB rd=r0 of r1-r1 with `we=1`, `fe=1` → `rsp_result=0`, z=1; a later read of r0 still returns 0.
- **Backpressure:**
  - Hold `rsp_ready=0` and issue 3 commands → the first two are accepted, and `cmd_ready` drops after the second.
  - `alu_*` stays stable while stalled.
  - Release `rsp_ready` → three responses in order, with no loss or duplication.
- **Forwarding chain:** 16 consecutive ADD r1=r1+imm 1 with `rsp_ready=1` → the final `rsp_result` equals 16; one response per cycle after the first.
- **Random:** 1000 random commands with a random `rsp_ready` against a reference model of registers, flags and `alu32` → zero mismatches.
